// File: rtl/counter_display_pkg.sv
// Shared definitions for the counter display: segment patterns, converter FSM
// states and a digit-count helper used for the elaboration check.
package counter_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Active-low patterns {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // ceil(len * log10(2)) in integer arithmetic: decimal digits of 2^len-1.
    function automatic int unsigned min_digits(input int unsigned len);
        return (len * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/counter_display_if.sv
// Value/segment/select/busy bundle between the counter and the display stage.
interface counter_display_if #(
    parameter int LEN    = 8,
    parameter int DIGITS = 4
);
    logic [LEN-1:0]    value;
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;
    logic              busy;

    modport master (output value, input seg, input sel, input busy);
    modport slave  (input value, output seg, output sel, output busy);
endinterface

// File: rtl/counter_display_bin_to_bcd.sv
// Sequential double-dabble converter: one binary bit shifted into the BCD
// scratch per clock, LEN shifts per conversion, then a single DONE cycle.
module bin_to_bcd
    import counter_display_pkg::*;
#(
    parameter int LEN    = 8,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [LEN-1:0]      value_i,
    output logic                idle_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] bcd_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int BIT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LEN - 1);

    state_e           state_q, state_d;
    logic [LEN-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d   = value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                // bcd_q is final here; the top latches it on done_o.
                done_o  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign idle_o = (state_q == ST_IDLE);
    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/counter_display.sv
// Seven-segment display stage: converts the counter value to BCD and scans it
// across DIGITS multiplexed digits with leading-zero blanking.
module counter_display
    import counter_display_pkg::*;
#(
    parameter int LEN          = 8,
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_display_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = REFRESH_BITS + IDX_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DIGITS << REFRESH_BITS) - 1);

    generate
        if (DIGITS < int'(min_digits(LEN))) begin : g_digits_too_few
            $error("counter_display: DIGITS too small to show a LEN-bit value");
        end
    endgenerate

    logic [LEN-1:0]    shadow_q, shadow_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    logic              conv_idle, conv_busy, conv_done, start;
    logic [BCD_W-1:0]  conv_bcd;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS-1:0] blank_v;
    logic              lead_zero, digit_blank;
    logic [3:0]        nib;

    assign start = conv_idle && (bus.value != shadow_q);

    bin_to_bcd #(
        .LEN    (LEN),
        .DIGITS (DIGITS)
    ) u_bin_to_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .value_i (bus.value),
        .idle_o  (conv_idle),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign idx = cnt_q[CNT_W-1 -: IDX_W];

    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        if (start)     shadow_d = bus.value;
        if (conv_done) disp_d   = conv_bcd;
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

        // A digit is blank when it and every digit above it are zero; digit 0 never is.
        lead_zero = 1'b1;
        blank_v   = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_zero  = lead_zero && (disp_q[4*i +: 4] == 4'd0);
            blank_v[i] = lead_zero;
        end

        nib         = 4'd0;
        digit_blank = 1'b0;
        sel_d       = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib         = disp_q[4*i +: 4];
                digit_blank = blank_v[i];
                sel_d[i]    = 1'b0;
            end
        end
        seg_d = digit_blank ? SEG_BLANK : seg_encode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            disp_q   <= '0;
            cnt_q    <= '0;
            seg_q    <= SEG_BLANK;
            sel_q    <= '1;
        end else begin
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.sel  = sel_q;
    assign bus.busy = conv_busy;

endmodule

// File: tb/tb_counter_display.sv
// Bench for counter_display: decimal reference model of the digits, the scan
// order and the conversion latency, with directed and random values.
module tb_counter_display;

    localparam int LEN    = 8;
    localparam int DIGITS = 4;
    localparam int RB     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_display_if #(.LEN(LEN), .DIGITS(DIGITS)) bus ();

    counter_display #(
        .LEN          (LEN),
        .DIGITS       (DIGITS),
        .REFRESH_BITS (RB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int shown = 0;

    function automatic logic [7:0] digit_pat(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Decimal digit i of v, blank when v has fewer than i+1 digits (except i=0).
    function automatic logic [7:0] exp_seg(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i > 0 && v < p) return 8'hFF;
        return digit_pat((v / p) % 10);
    endfunction

    function automatic int exp_idx();
        return ((cyc - 1) >> RB) % DIGITS;
    endfunction

    function automatic logic [DIGITS-1:0] exp_sel(input int idx);
        logic [DIGITS-1:0] s;
        s = '1;
        s[idx] = 1'b0;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.value = '0;
        repeat (3) step();
        tests++; if (bus.seg !== 8'hFF) begin fails++; $display("FAIL rst_seg: got %h want ff", bus.seg); end
        tests++; if (bus.sel !== 4'hF) begin fails++; $display("FAIL rst_sel: got %h want f", bus.sel); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        cyc = 0;
        shown = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            tests++; if (bus.sel !== exp_sel(exp_idx())) begin fails++; $display("FAIL rst_scan_sel: got %h want %h", bus.sel, exp_sel(exp_idx())); end
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL rst_scan_seg: digit %0d got %h want %h", exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
            tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy); end
        end
    endtask

    task automatic test_latency_255();
        int n;
        int old;
        old = shown;
        bus.value = 8'd255;
        step();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
        tests++; if (n != LEN + 1) begin fails++; $display("FAIL l255_busy_len: got %0d want %0d", n, LEN + 1); end
        tests++; if (bus.seg !== exp_seg(old, exp_idx())) begin fails++; $display("FAIL l255_pre_update: got %h want %h", bus.seg, exp_seg(old, exp_idx())); end
        shown = 255;
        for (int c = 0; c < 16; c++) begin
            step();
            tests++; if (bus.sel !== exp_sel(exp_idx())) begin fails++; $display("FAIL l255_sel: got %h want %h", bus.sel, exp_sel(exp_idx())); end
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL l255_seg: digit %0d got %h want %h", exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
        end
    endtask

    task automatic test_inner_zeros();
        int n;
        bus.value = 8'd100;
        step();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
        tests++; if (n != LEN + 1) begin fails++; $display("FAIL z100_busy_len: got %0d want %0d", n, LEN + 1); end
        shown = 100;
        for (int c = 0; c < 16; c++) begin
            step();
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL z100_seg: digit %0d got %h want %h", exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.value = 8'd7;
        step();
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_start: got %b want 1", bus.busy); end
        step();
        step();
        bus.value = 8'd42;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
        tests++; if (n != LEN - 1) begin fails++; $display("FAIL b2b_first_len: got %0d want %0d", n, LEN - 1); end
        shown = 7;
        step();
        tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL b2b_first_shown: got %h want %h", bus.seg, exp_seg(shown, exp_idx())); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_restart: got %b want 1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
        tests++; if (n != LEN + 1) begin fails++; $display("FAIL b2b_second_len: got %0d want %0d", n, LEN + 1); end
        tests++; if (bus.seg !== exp_seg(7, exp_idx())) begin fails++; $display("FAIL b2b_pre_update: got %h want %h", bus.seg, exp_seg(7, exp_idx())); end
        shown = 42;
        for (int c = 0; c < 16; c++) begin
            step();
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL b2b_seg: digit %0d got %h want %h", exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
        end
    endtask

    task automatic test_stable();
        for (int c = 0; c < 100; c++) begin
            step();
            tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stable_busy: cycle %0d got %b want 0", c, bus.busy); end
            tests++; if (bus.sel !== exp_sel(exp_idx())) begin fails++; $display("FAIL stable_sel: cycle %0d got %h want %h", c, bus.sel, exp_sel(exp_idx())); end
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL stable_seg: cycle %0d got %h want %h", c, bus.seg, exp_seg(shown, exp_idx())); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.value = 8'd200;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.seg !== 8'hFF) begin fails++; $display("FAIL mid_rst_seg: got %h want ff", bus.seg); end
        tests++; if (bus.sel !== 4'hF) begin fails++; $display("FAIL mid_rst_sel: got %h want f", bus.sel); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        shown = 0;
        step();
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_restart: got %b want 1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
        tests++; if (n != LEN + 1) begin fails++; $display("FAIL mid_busy_len: got %0d want %0d", n, LEN + 1); end
        tests++; if (bus.seg !== exp_seg(0, exp_idx())) begin fails++; $display("FAIL mid_pre_update: got %h want %h", bus.seg, exp_seg(0, exp_idx())); end
        shown = 200;
        for (int c = 0; c < 16; c++) begin
            step();
            tests++; if (bus.sel !== exp_sel(exp_idx())) begin fails++; $display("FAIL mid_sel: got %h want %h", bus.sel, exp_sel(exp_idx())); end
            tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL mid_seg: digit %0d got %h want %h", exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
        end
    endtask

    task automatic test_random();
        int v;
        int n;
        for (int r = 0; r < 10; r++) begin
            v = (r == 0) ? shown : int'($urandom_range(0, 255));
            bus.value = LEN'(v);
            if (v == shown) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rand_no_retrigger: value %0d got %b want 0", v, bus.busy); end
                end
            end else begin
                step();
                n = 0;
                while (bus.busy === 1'b1 && n < 40) begin n++; step(); end
                tests++; if (n != LEN + 1) begin fails++; $display("FAIL rand_busy_len: value %0d got %0d want %0d", v, n, LEN + 1); end
                shown = v;
                for (int c = 0; c < 16; c++) begin
                    step();
                    tests++; if (bus.seg !== exp_seg(shown, exp_idx())) begin fails++; $display("FAIL rand_seg: value %0d digit %0d got %h want %h", v, exp_idx(), bus.seg, exp_seg(shown, exp_idx())); end
                end
            end
            repeat ($urandom_range(0, 5)) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.value = '0;
        test_reset();
        test_latency_255();
        test_inner_zeros();
        test_back_to_back();
        test_stable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
